adc_3wire_slave: RTL and testbench

ADC_3WIRE_SLAVE -- requirements
Module: adc_3wire_slave

---
 rtl/adc_3wire_slave.sv | 176 +++++++++++++++++
 tb/tb_adc_3wire_slave.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_3wire_slave.sv
// adc_3wire_slave
// Three-wire (clock / strobe / data) configuration slave with eight 16-bit
// registers. A frame is 20 bits, MSB first, framed by an active-low strobe:
// [19:17] address, [16:1] data, [0] commit bit (value ignored).
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ctrl_clk_i          serial clock from the config master
//   ctrl_strb_i         serial strobe, active low
//   ctrl_data_i         serial data, MSB first
//   rd_addr_i/rd_data_o registered register read port (write bypass)
//   wr_valid_o          one-cycle pulse per committed write
//   wr_addr_o/wr_data_o address/data of the last committed write
//   frame_active_o      high while a frame is being shifted in
//   frame_err_o         one-cycle pulse per discarded frame
//   err_count_o         discarded-frame counter (saturating)
//
// Optional feature: define ADC3W_ERR_CNT_EN to build the discarded-frame
// counter; otherwise err_count_o is tied to zero.
module adc_3wire_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] REG_RST     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_clk_i,
    input  logic        ctrl_strb_i,
    input  logic        ctrl_data_i,
    input  logic [2:0]  rd_addr_i,
    output logic [15:0] rd_data_o,
    output logic        wr_valid_o,
    output logic [2:0]  wr_addr_o,
    output logic [15:0] wr_data_o,
    output logic        frame_active_o,
    output logic        frame_err_o,
    output logic [7:0]  err_count_o
);

    localparam int LAST = SYNC_STAGES - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] strb_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [SYNC_STAGES:0]   fill;
    logic                   sclk_s, strb_s, data_s;
    logic                   sclk_d, strb_d;
    logic                   armed;
    logic                   sclk_rise_r, strb_fall_r, strb_rise_r, data_r;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [19:0] shreg;
    logic [15:0] regs [8];

    // ---- stage 0: input synchronizers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            strb_sync <= '1;
            data_sync <= '0;
            fill      <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ctrl_clk_i};
            strb_sync <= {strb_sync[SYNC_STAGES-2:0], ctrl_strb_i};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ctrl_data_i};
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s = sclk_sync[LAST];
    assign strb_s = strb_sync[LAST];
    assign data_s = data_sync[LAST];

    // Strobe edges are only trusted once both the synchronized value and its
    // delayed copy come from samples taken after reset; otherwise a strobe
    // that was already low at reset release would look like a falling edge.
    assign armed = fill[SYNC_STAGES];

    // ---- stage 1: registered edge detection ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d      <= 1'b0;
            strb_d      <= 1'b1;
            sclk_rise_r <= 1'b0;
            strb_fall_r <= 1'b0;
            strb_rise_r <= 1'b0;
            data_r      <= 1'b0;
        end else begin
            sclk_d      <= sclk_s;
            strb_d      <= strb_s;
            sclk_rise_r <= sclk_s & ~sclk_d;
            strb_fall_r <= armed & strb_d & ~strb_s;
            strb_rise_r <= armed & ~strb_d & strb_s;
            data_r      <= data_s;
        end
    end

    // ---- stage 2: frame FSM, register file and read port ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            wr_valid_o  <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            frame_err_o <= 1'b0;
            rd_data_o   <= REG_RST;
            for (int i = 0; i < 8; i++) regs[i] <= REG_RST;
        end else begin
            wr_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            rd_data_o   <= regs[rd_addr_i];
            case (state)
                IDLE: begin
                    if (strb_fall_r) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                SHIFT: begin
                    // Strobe rise wins over a coincident clock rise.
                    if (strb_rise_r) begin
                        if (bit_cnt == 5'd20) begin
                            state <= COMMIT;
                        end else begin
                            state       <= IDLE;
                            frame_err_o <= 1'b1;
                        end
                    end else if (sclk_rise_r) begin
                        shreg <= {shreg[18:0], data_r};
                        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                COMMIT: begin
                    regs[shreg[19:17]] <= shreg[16:1];
                    wr_valid_o         <= 1'b1;
                    wr_addr_o          <= shreg[19:17];
                    wr_data_o          <= shreg[16:1];
                    if (rd_addr_i == shreg[19:17]) rd_data_o <= shreg[16:1];
                    // A new frame may start immediately after the previous one.
                    if (strb_fall_r) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign frame_active_o = (state == SHIFT);

`ifdef ADC3W_ERR_CNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (frame_err_o && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_count_o = err_cnt;
`else
    assign err_count_o = 8'h00;
`endif

endmodule

// File: tb/tb_adc_3wire_slave.sv
// Testbench for adc_3wire_slave: directed scenarios followed by random frames,
// compared against a register-level model of the slave.
module tb_adc_3wire_slave;

    localparam int          S       = 2;
    localparam logic [15:0] RST_VAL = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        strb = 1'b1;
    logic        sdata = 1'b0;
    logic [2:0]  rd_addr = 3'd0;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_active;
    logic        frame_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    adc_3wire_slave #(.SYNC_STAGES(S), .REG_RST(RST_VAL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_clk_i     (sclk),
        .ctrl_strb_i    (strb),
        .ctrl_data_i    (sdata),
        .rd_addr_i      (rd_addr),
        .rd_data_o      (rd_data),
        .wr_valid_o     (wr_valid),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .frame_active_o (frame_active),
        .frame_err_o    (frame_err),
        .err_count_o    (err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters observed on the DUT outputs.
    int wr_seen  = 0;
    int err_seen = 0;

    always @(negedge clk) begin
        if (wr_valid)  wr_seen  = wr_seen + 1;
        if (frame_err) err_seen = err_seen + 1;
    end

    // Reference model: register contents and expected event totals.
    logic [15:0] model [8];
    int          exp_wr = 0;
    int          exp_err = 0;
    int          exp_hw_err = 0;
    logic [2:0]  exp_wa = 3'd0;
    logic [15:0] exp_wd = 16'h0;

    int          lat;
    logic [15:0] rd_at_commit;
    logic        act_mid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Shift bits MSB first; data changes while sclk is low.
    task automatic shift_bits(input logic [19:0] fr, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            sdata = fr[19 - (i % 20)];
            wait_clks(half);
            sclk = 1'b1;
            act_mid = frame_active;
            wait_clks(half);
            sclk = 1'b0;
        end
    endtask

    // Raise the strobe and record how many clk edges after the first edge
    // that samples it high the write pulse appears (-1 if none).
    task automatic strobe_rise_measure(output int k);
        strb = 1'b1;
        k = -1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr_valid && k < 0) begin
                k = c;
                rd_at_commit = rd_data;
            end
        end
        wait_clks(1);
    endtask

    task automatic model_frame(input logic [2:0] a, input logic [15:0] d, input int nbits);
        if (nbits == 20) begin
            model[a] = d;
            exp_wr++;
            exp_wa = a;
            exp_wd = d;
        end else begin
            exp_err++;
            if (exp_hw_err < 255) exp_hw_err++;
        end
    endtask

    task automatic frame(input logic [2:0] a, input logic [15:0] d, input logic cb,
                         input int nbits, input int half);
        strb = 1'b0;
        wait_clks(half);
        shift_bits({a, d, cb}, nbits, half);
        wait_clks(half);
        strobe_rise_measure(lat);
        model_frame(a, d, nbits);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model[i] = RST_VAL;
        exp_hw_err = 0;
        exp_wa = 3'd0;
        exp_wd = 16'h0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_wr_pulses"}, wr_seen, exp_wr);
        check({tag, "_err_pulses"}, err_seen, exp_err);
`ifdef ADC3W_ERR_CNT_EN
        check({tag, "_err_count"}, err_count, exp_hw_err);
`else
        check({tag, "_err_count"}, err_count, 0);
`endif
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 8; a++) begin
            rd_addr = a[2:0];
            wait_clks(2);
            check($sformatf("%s_reg%0d", tag, a), rd_data, model[a]);
        end
    endtask

    initial begin
        model_reset();

        // Reset state
        rst_n = 1'b0;
        wait_clks(3);
        check("rst_rd_data", rd_data, RST_VAL);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_frame_active", frame_active, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        wait_clks(5);

        // Master-style frame: sclk period 128 clk
        frame(3'd0, 16'h7CBC, 1'b0, 20, 64);
        check("m_latency", lat, S + 2);
        check("m_wr_addr", wr_addr, 0);
        check("m_wr_data", wr_data, 16'h7CBC);
        check_counts("m");
        rd_addr = 3'd0;
        wait_clks(1);
        check("m_rd0", rd_data, 16'h7CBC);

        // Short frame: 10 bits only
        frame(3'd1, 16'hFFFF, 1'b1, 10, 16);
        check("short_active_mid", act_mid, 1);
        check("short_active_after", frame_active, 0);
        check("short_hold_addr", wr_addr, exp_wa);
        check("short_hold_data", wr_data, exp_wd);
        check_counts("short");
        check_regs("short");

        // Back-to-back frames, second strobe fall 1 clk after first rise
        strb = 1'b0;
        wait_clks(16);
        shift_bits({3'd3, 16'h1234, 1'b1}, 20, 16);
        wait_clks(16);
        strb = 1'b1;
        wait_clks(1);
        strb = 1'b0;
        wait_clks(16);
        shift_bits({3'd5, 16'hBEEF, 1'b0}, 20, 16);
        wait_clks(16);
        strobe_rise_measure(lat);
        model_frame(3'd3, 16'h1234, 20);
        model_frame(3'd5, 16'hBEEF, 20);
        check("b2b_latency", lat, S + 2);
        check("b2b_wr_addr", wr_addr, 5);
        check("b2b_wr_data", wr_data, 16'hBEEF);
        check_counts("b2b");
        check_regs("b2b");

        // Read bypass: address 6 held during its own commit
        rd_addr = 3'd6;
        wait_clks(2);
        frame(3'd6, 16'hA5A5, 1'b1, 20, 16);
        check("byp_latency", lat, S + 2);
        check("byp_rd_data", rd_at_commit, 16'hA5A5);
        check_counts("byp");

        // Reset in the middle of a frame, then a full frame
        strb = 1'b0;
        wait_clks(16);
        shift_bits({3'd2, 16'h5555, 1'b0}, 8, 16);
        rst_n = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        model_reset();
        wait_clks(10);
        strb = 1'b1;
        wait_clks(12);
        check("midrst_active", frame_active, 0);
        check_counts("midrst");
        frame(3'd2, 16'h00FF, 1'b0, 20, 16);
        check("midrst_wr_data", wr_data, 16'h00FF);
        check_counts("midrst_full");
        check_regs("midrst");

        // Strobe already low at reset release, clocks shifted, then strobe high
        rst_n = 1'b0;
        strb = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        model_reset();
        wait_clks(5);
        shift_bits({3'd4, 16'hCAFE, 1'b1}, 20, 8);
        check("lowrst_active_mid", act_mid, 0);
        wait_clks(8);
        strb = 1'b1;
        wait_clks(12);
        check("lowrst_active", frame_active, 0);
        check("lowrst_wr_data", wr_data, 0);
        check_counts("lowrst");

        // Random frames, some of them with a wrong bit count
        for (int n = 0; n < 10; n++) begin
            logic [2:0]  a;
            logic [15:0] d;
            int          nb;
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : 20;
            rd_addr = 3'($urandom_range(0, 7));
            frame(a, d, 1'($urandom), nb, int'($urandom_range(4, 12)));
            if (nb == 20) check($sformatf("rnd%0d_latency", n), lat, S + 2);
            else          check($sformatf("rnd%0d_nowrite", n), lat, 32'hFFFF_FFFF);
            check($sformatf("rnd%0d_wr_addr", n), wr_addr, exp_wa);
            check($sformatf("rnd%0d_wr_data", n), wr_data, exp_wd);
            check_counts($sformatf("rnd%0d", n));
        end
        check_regs("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
